// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S core: decoder output encoding, sequencer states, ALU opcodes.
// Pure declarations, no logic.
package k_and_s_pkg;

   typedef enum logic [4:0] {
      I_NOP    = 5'd0,
      I_LOAD   = 5'd1,
      I_STORE  = 5'd2,
      I_MOVE   = 5'd3,
      I_ADD    = 5'd4,
      I_SUB    = 5'd5,
      I_AND    = 5'd6,
      I_OR     = 5'd7,
      I_BRANCH = 5'd8,
      I_BZERO  = 5'd9,
      I_BNZERO = 5'd10,
      I_BNEG   = 5'd11,
      I_BNNEG  = 5'd12,
      I_BOV    = 5'd13,
      I_BNOV   = 5'd14,
      I_HALT   = 5'd15
   } decoded_instruction_type;

   typedef enum logic [3:0] {
      S_FETCH,
      S_IR_LOAD,
      S_DECODE,
      S_LOAD_RD,
      S_LOAD_WB,
      S_STORE,
      S_ALU,
      S_MOVE,
      S_BR_TAKE,
      S_RETIRE,
      S_HALT,
      S_STEP_WAIT
   } ctrl_state_t;

   localparam logic [1:0] ALU_OR  = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;
   localparam logic [1:0] ALU_AND = 2'b11;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the K&S datapath; optional KS_SINGLE_STEP_EN stall after retire.
// Latency: MEM_RD_LAT+3 cycles (NOP/untaken), +1 for ALU/MOVE/STORE/taken branch, +MEM_RD_LAT+1 for LOAD.
// Backpressure: none; only step_req (single-step build) can hold the core between instructions.
module control_unit
   import k_and_s_pkg::*;
#(
   parameter int MEM_RD_LAT  = 1,
   parameter int INSTR_CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
`ifdef KS_SINGLE_STEP_EN
   input  logic                    step_req,
   output logic                    step_idle,
`endif
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic [1:0]              operation,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
   output logic                    halted,
   output logic [INSTR_CNT_W-1:0]  instr_count
);

   localparam int CNT_W = $clog2(MEM_RD_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_RD_LAT - 1);

   ctrl_state_t            state_q, state_d;
   logic [CNT_W-1:0]       wait_q, wait_d;
   logic [INSTR_CNT_W-1:0] count_q, count_d;

   // No branch in the ISA tests the unsigned carry flag.
   logic unused_flags;
   assign unused_flags = unsigned_overflow;

   function automatic logic cond_true(decoded_instruction_type ins, logic z, logic n, logic v);
      logic t;
      t = 1'b0;
      case (ins)
         I_BRANCH: t = 1'b1;
         I_BZERO:  t = z;
         I_BNZERO: t = !z;
         I_BNEG:   t = n;
         I_BNNEG:  t = !n;
         I_BOV:    t = v;
         I_BNOV:   t = !v;
         default:  t = 1'b0;
      endcase
      return t;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      count_d = count_q;
      case (state_q)
         S_FETCH: begin
            if (wait_q == LAT_LAST) state_d = S_IR_LOAD;
            else                    wait_d  = wait_q + CNT_W'(1);
         end
         S_IR_LOAD: state_d = S_DECODE;
         S_DECODE: begin
            case (decoded_instruction)
               I_LOAD:                    state_d = S_LOAD_RD;
               I_STORE:                   state_d = S_STORE;
               I_ADD, I_SUB, I_AND, I_OR: state_d = S_ALU;
               I_MOVE:                    state_d = S_MOVE;
               I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                  state_d = cond_true(decoded_instruction, zero_op, neg_op, signed_overflow)
                            ? S_BR_TAKE : S_RETIRE;
               I_HALT: begin
                  state_d = S_HALT;
                  count_d = count_q + INSTR_CNT_W'(1);
               end
               default:                   state_d = S_RETIRE;
            endcase
         end
         S_LOAD_RD: begin
            if (wait_q == LAT_LAST) state_d = S_LOAD_WB;
            else                    wait_d  = wait_q + CNT_W'(1);
         end
         S_LOAD_WB, S_STORE, S_ALU, S_MOVE, S_BR_TAKE: state_d = S_RETIRE;
         S_RETIRE: begin
            count_d = count_q + INSTR_CNT_W'(1);
`ifdef KS_SINGLE_STEP_EN
            state_d = S_STEP_WAIT;
`else
            state_d = S_FETCH;
`endif
         end
         S_STEP_WAIT: begin
`ifdef KS_SINGLE_STEP_EN
            if (step_req) state_d = S_FETCH;
`else
            state_d = S_FETCH;
`endif
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Strobes are forced low during reset so an abandoned instruction never writes.
   always_comb begin
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = ALU_OR;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halted           = 1'b0;
      instr_count      = '0;
`ifdef KS_SINGLE_STEP_EN
      step_idle        = 1'b0;
`endif
      if (!rst) begin
         instr_count = count_q;
         case (state_q)
            S_IR_LOAD: begin
               ir_enable = 1'b1;
               pc_enable = 1'b1;
            end
            S_LOAD_RD: addr_sel = 1'b1;
            S_LOAD_WB: begin
               addr_sel         = 1'b1;
               write_reg_enable = 1'b1;
            end
            S_STORE: begin
               addr_sel         = 1'b1;
               ram_write_enable = 1'b1;
            end
            S_ALU: begin
               c_sel            = 1'b1;
               write_reg_enable = 1'b1;
               flags_reg_enable = 1'b1;
               case (decoded_instruction)
                  I_ADD:   operation = ALU_ADD;
                  I_SUB:   operation = ALU_SUB;
                  I_AND:   operation = ALU_AND;
                  default: operation = ALU_OR;
               endcase
            end
            S_MOVE: begin
               c_sel            = 1'b1;
               write_reg_enable = 1'b1;
            end
            S_BR_TAKE: begin
               pc_enable = 1'b1;
               branch    = 1'b1;
            end
            S_HALT: halted = 1'b1;
`ifdef KS_SINGLE_STEP_EN
            S_STEP_WAIT: step_idle = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule
